// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB bypass onto the ALU inputs and immediate select for src2.
// One-edge latency from id_* to ex_*/alu_*; a load-use hazard raises stall and inserts one bubble (flush wins).
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alu_src,
  input  logic [CTRL_W-1:0] id_alu_control,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_control,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              stall,
  output logic [15:0]       bubble_count
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              use_rs1;
    logic              use_rs2;
    logic [DATA_W-1:0] rs1_dat;
    logic [DATA_W-1:0] rs2_dat;
    logic [DATA_W-1:0] imm;
    logic              alu_src;
    logic [CTRL_W-1:0] alu_control;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } ex_reg_t;

  ex_reg_t ex_q;
  ex_reg_t ex_d;

  logic              load_use;
  logic [DATA_W-1:0] src1_fwd;
  logic [DATA_W-1:0] src2_fwd;

  always_comb begin
    load_use = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
               ((id_use_rs1 & (id_rs1 == ex_q.rd)) | (id_use_rs2 & (id_rs2 == ex_q.rd)));
    stall    = load_use & ~flush;
  end

  // Flush and stall both load an all-zero bubble; an idle decode slot clears controls only.
  always_comb begin
    ex_d = '0;
    if (!flush && !stall) begin
      ex_d.valid       = id_valid;
      ex_d.rs1         = id_rs1;
      ex_d.rs2         = id_rs2;
      ex_d.rd          = id_rd;
      ex_d.use_rs1     = id_use_rs1;
      ex_d.use_rs2     = id_use_rs2;
      ex_d.rs1_dat     = id_rs1_data;
      ex_d.rs2_dat     = id_rs2_data;
      ex_d.imm         = id_imm;
      ex_d.alu_src     = id_alu_src;
      ex_d.alu_control = id_valid ? id_alu_control : '0;
      ex_d.reg_write   = id_valid & id_reg_write;
      ex_d.mem_read    = id_valid & id_mem_read;
      ex_d.mem_write   = id_valid & id_mem_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count <= '0;
    end else if (stall && (bubble_count != 16'hFFFF)) begin
      bubble_count <= bubble_count + 16'd1;
    end
  end

  // EX/MEM is the younger producer, so it outranks MEM/WB; r0 is hardwired zero.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic              used,
    input logic [REG_AW-1:0] idx,
    input logic [DATA_W-1:0] rf_dat,
    input logic              em_we,
    input logic [REG_AW-1:0] em_rd,
    input logic [DATA_W-1:0] em_res,
    input logic              mw_we,
    input logic [REG_AW-1:0] mw_rd,
    input logic [DATA_W-1:0] mw_res
  );
    logic [DATA_W-1:0] sel;
    if (idx == '0) begin
      sel = '0;
    end else if (used && em_we && (em_rd == idx)) begin
      sel = em_res;
    end else if (used && mw_we && (mw_rd == idx)) begin
      sel = mw_res;
    end else begin
      sel = rf_dat;
    end
    return sel;
  endfunction

  always_comb begin
    src1_fwd = fwd_sel(ex_q.use_rs1, ex_q.rs1, ex_q.rs1_dat,
                       exmem_reg_write, exmem_rd, exmem_result,
                       memwb_reg_write, memwb_rd, memwb_result);
    src2_fwd = fwd_sel(ex_q.use_rs2, ex_q.rs2, ex_q.rs2_dat,
                       exmem_reg_write, exmem_rd, exmem_result,
                       memwb_reg_write, memwb_rd, memwb_result);
  end

  always_comb begin
    alu_a         = src1_fwd;
    alu_b         = ex_q.alu_src ? ex_q.imm : src2_fwd;
    ex_store_data = src2_fwd;
    alu_control   = ex_q.alu_control;
    ex_valid      = ex_q.valid;
    ex_reg_write  = ex_q.reg_write;
    ex_mem_read   = ex_q.mem_read;
    ex_mem_write  = ex_q.mem_write;
    ex_rd         = ex_q.rd;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, issue, bypass priority, r0/immediate, load-use stall, flush, reset mid-stall.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [2:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2;
  logic [15:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_alu_src;
  logic [3:0]  id_alu_control;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        flush;
  logic        exmem_reg_write;
  logic [2:0]  exmem_rd;
  logic [15:0] exmem_result;
  logic        memwb_reg_write;
  logic [2:0]  memwb_rd;
  logic [15:0] memwb_result;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_control;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_rd;
  logic [15:0] ex_store_data;
  logic        stall;
  logic [15:0] bubble_count;

  int checks;
  int failures;

  id_ex_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .id_rs1_data    (id_rs1_data),
    .id_rs2_data    (id_rs2_data),
    .id_imm         (id_imm),
    .id_alu_src     (id_alu_src),
    .id_alu_control (id_alu_control),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .id_mem_write   (id_mem_write),
    .flush          (flush),
    .exmem_reg_write(exmem_reg_write),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_reg_write(memwb_reg_write),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_control    (alu_control),
    .ex_valid       (ex_valid),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_rd          (ex_rd),
    .ex_store_data  (ex_store_data),
    .stall          (stall),
    .bubble_count   (bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic vld, input logic [2:0] rs1, input logic [2:0] rs2,
                          input logic [2:0] rd, input logic u1, input logic u2,
                          input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] imm,
                          input logic src, input logic [3:0] ctrl,
                          input logic rw, input logic mr, input logic mw);
    id_valid = vld;  id_rs1 = rs1;  id_rs2 = rs2;  id_rd = rd;
    id_use_rs1 = u1; id_use_rs2 = u2;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    id_alu_src = src; id_alu_control = ctrl;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic clear_bypass();
    exmem_reg_write = 1'b0; exmem_rd = 3'd0; exmem_result = 16'h0;
    memwb_reg_write = 1'b0; memwb_rd = 3'd0; memwb_result = 16'h0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    drive_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    clear_bypass();
    #3;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_alu_ctrl", alu_control, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_bubbles", bubble_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain issue, no bypass hits
    drive_id(1'b1, 3'd1, 3'd2, 3'd4, 1'b1, 1'b1, 16'h0005, 16'h0003, 16'h0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0);
    step();
    check("plain_alu_a", alu_a, 16'h0005);
    check("plain_alu_b", alu_b, 16'h0003);
    check("plain_ex_valid", ex_valid, 1);
    check("plain_alu_ctrl", alu_control, 4'h1);
    check("plain_ex_rd", ex_rd, 3'd4);
    check("plain_reg_write", ex_reg_write, 1);

    // Bypass priority on src1 = r2
    drive_id(1'b1, 3'd2, 3'd6, 3'd1, 1'b1, 1'b1, 16'h0AAA, 16'h0006, 16'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    step();
    drive_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    exmem_reg_write = 1'b1; exmem_rd = 3'd2; exmem_result = 16'h1111;
    memwb_reg_write = 1'b1; memwb_rd = 3'd2; memwb_result = 16'h2222;
    #1;
    check("fwd_exmem_wins", alu_a, 16'h1111);
    exmem_reg_write = 1'b0;
    #1;
    check("fwd_memwb", alu_a, 16'h2222);
    memwb_reg_write = 1'b0;
    #1;
    check("fwd_none", alu_a, 16'h0AAA);
    clear_bypass();

    // r0 stays zero; immediate on src2, store data from forwarded rs2
    drive_id(1'b1, 3'd0, 3'd5, 3'd0, 1'b1, 1'b1, 16'h1234, 16'h0000, 16'h0010, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
    step();
    drive_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    exmem_reg_write = 1'b1; exmem_rd = 3'd0; exmem_result = 16'hFFFF;
    memwb_reg_write = 1'b1; memwb_rd = 3'd5; memwb_result = 16'hBEEF;
    #1;
    check("r0_alu_a", alu_a, 16'h0000);
    check("imm_alu_b", alu_b, 16'h0010);
    check("store_data", ex_store_data, 16'hBEEF);
    check("store_mem_write", ex_mem_write, 1);
    clear_bypass();

    // Load r3 then dependent add reading r3
    drive_id(1'b1, 3'd1, 3'd0, 3'd3, 1'b1, 1'b0, 16'h0100, 16'h0, 16'h0004, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
    step();
    check("load_mem_read", ex_mem_read, 1);
    drive_id(1'b1, 3'd3, 3'd2, 3'd5, 1'b1, 1'b1, 16'h0000, 16'h0007, 16'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    #1;
    check("lu_stall", stall, 1);
    step();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_rw", ex_reg_write, 0);
    check("lu_bubble_count", bubble_count, 1);
    check("lu_stall_drop", stall, 0);
    step();
    drive_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    memwb_reg_write = 1'b1; memwb_rd = 3'd3; memwb_result = 16'h55AA;
    #1;
    check("lu_issue_valid", ex_valid, 1);
    check("lu_issue_rd", ex_rd, 3'd5);
    check("lu_memwb_fwd", alu_a, 16'h55AA);
    check("lu_alu_b", alu_b, 16'h0007);
    clear_bypass();

    // Same register but operand not read: no stall
    drive_id(1'b1, 3'd1, 3'd0, 3'd3, 1'b1, 1'b0, 16'h0100, 16'h0, 16'h0004, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
    step();
    drive_id(1'b1, 3'd3, 3'd3, 3'd6, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0009, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
    #1;
    check("nouse_stall", stall, 0);
    step();
    check("nouse_valid", ex_valid, 1);
    check("nouse_bubbles", bubble_count, 1);

    // Flush coinciding with a load-use hazard
    drive_id(1'b1, 3'd1, 3'd0, 3'd3, 1'b1, 1'b0, 16'h0100, 16'h0, 16'h0004, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
    step();
    drive_id(1'b1, 3'd3, 3'd2, 3'd5, 1'b1, 1'b1, 16'h0, 16'h0007, 16'h0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_stall", stall, 0);
    step();
    flush = 1'b0;
    check("flush_valid", ex_valid, 0);
    check("flush_rw", ex_reg_write, 0);
    check("flush_bubbles", bubble_count, 1);

    // Reset while a stall is being requested
    drive_id(1'b1, 3'd1, 3'd0, 3'd3, 1'b1, 1'b0, 16'h0100, 16'h0, 16'h0004, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0);
    step();
    drive_id(1'b1, 3'd2, 3'd3, 3'd5, 1'b1, 1'b1, 16'h0001, 16'h0, 16'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    #1;
    check("mid_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", stall, 0);
    check("mid_rst_valid", ex_valid, 0);
    check("mid_rst_ctrl", alu_control, 0);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_bubbles", bubble_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage feeding the 16-bit ALU. It registers decoded operands and control, forwards results from the EX/MEM and MEM/WB stages onto the ALU inputs, and selects the immediate for src2. It also detects load-use hazards, requesting a one-cycle stall and inserting a bubble. It sits between the decoder/register file and the ALU.

## Interface
- DATA_W, 16, datapath width
- REG_AW, 3, register index width (8 registers; r0 reads zero)
- CTRL_W, 4, ALU function-select width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode stage presents a valid instruction
- id_rs1, id_rs2, id_rd  in  REG_AW  source/destination indices
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
- id_rs1_data, id_rs2_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign/zero-extended immediate
- id_alu_src  in  1  1: ALU src2 = immediate; 0: src2 = rs2
- id_alu_control  in  CTRL_W  ALU function (0000 add … 0111 slt)
- id_reg_write, id_mem_read, id_mem_write  in  1  instruction control
- flush  in  1  branch taken: discard ID capture and current EX contents
- exmem_reg_write  in  1; exmem_rd  in  REG_AW; exmem_result  in  DATA_W  EX/MEM bypass source
- memwb_reg_write  in  1; memwb_rd  in  REG_AW; memwb_result  in  DATA_W  MEM/WB bypass source
- alu_a, alu_b  out  DATA_W  ALU src1/src2 after forwarding and immediate select
- alu_control  out  CTRL_W  registered ALU function
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control (all 0 for a bubble)
- ex_rd  out  REG_AW  registered destination
- ex_store_data  out  DATA_W  forwarded rs2 value (never the immediate)
- stall  out  1  combinational; hold PC and IF/ID this cycle
- bubble_count  out  16  saturating count of inserted load-use bubbles

## Operation
- Pipeline registers: valid, rs1, rs2, rd, use_rs1/2, rs1_data, rs2_data, imm, alu_src, alu_control, reg_write, mem_read, mem_write.
- Capture priority at each edge: flush > stall > normal.
  - flush: all registered controls cleared (ex_valid=0, reg_write/mem_read/mem_write=0, alu_control=0000); data fields are don't-care.
  - stall: insert a bubble (same clearing as flush). Upstream holds the ID instruction, which is re-presented next cycle.
  - normal: capture all id_* fields; ex_valid=id_valid. When id_valid=0, controls are cleared.
- Load-use hazard: stall = id_valid & ex_valid & ex_mem_read & (ex_rd≠0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). stall is forced to 0 while flush=1.
- Forwarding per operand (src1 from rs1, store/src2 from rs2), combinational from registered indices:
  - Index 0 → operand is 0; no forwarding.
  - exmem_reg_write & exmem_rd==idx → exmem_result. This has highest priority.
  - else memwb_reg_write & memwb_rd==idx → memwb_result.
  - else the registered register-file data.
- alu_b = alu_src ? imm : forwarded rs2. ex_store_data = forwarded rs2 always.
- bubble_count increments on each edge where stall=1 and flush=0. It saturates at 16'hFFFF.

## Timing
- Reset (async assert, sync-safe deassert in the clock domain):
  - all registered fields 0, bubble_count=0
  - therefore ex_valid=0, alu_control=0000, ex_rd=0, alu_a=0; alu_b is 0 unless the forwarding sources match index 0, which they cannot.
- Latency: an id_* instruction captured at edge N appears on ex_*/alu_* outputs after edge N; the ALU result is valid in the same cycle.
- alu_a/alu_b/ex_store_data and stall are combinational. They change in the same cycle as exmem_*/memwb_* inputs.
- Load-use: a load in EX with a dependent instruction in ID gives stall=1 for exactly one cycle. The bubble then occupies EX, so stall drops, and the dependent instruction is captured one edge later with the load in MEM/WB, forwarded via memwb.
- Simultaneous flush and stall: flush wins; no bubble is counted.
- Reset mid-stall: stall falls immediately, because ex_valid is cleared asynchronously.

## Test plan
- Reset: assert rst_n=0 mid-stream → ex_valid=0, alu_control=0000, alu_a=0, bubble_count=0 immediately.
- Plain issue: id rs1_data=0x0005, rs2_data=0x0003, alu_control=0001, alu_src=0, no matches → next cycle alu_a=0x0005, alu_b=0x0003, ex_valid=1.
- Forward priority: EX rs1=r2; exmem_rd=r2 with result 0x1111 and memwb_rd=r2 with result 0x2222, both reg_write=1 → alu_a=0x1111. Drop exmem_reg_write → alu_a=0x2222.
- r0 and immediate: rs1=r0 with exmem_rd=r0, result 0xFFFF → alu_a=0. alu_src=1, imm=0x0010, forwarded rs2=0xBEEF → alu_b=0x0010, ex_store_data=0xBEEF.
- Load-use: load to r3 in EX; ID add reads r3 (use_rs1=1) → stall=1 one cycle, next EX ex_valid=0, bubble_count=1. The add then issues with memwb forwarding of r3. With id_use_rs1=0 there is no stall.
- Flush: flush=1 together with a load-use condition → stall=0, next cycle ex_valid=0 and ex_reg_write=0, bubble_count unchanged.
